// File: rtl/rv_ctrl_pkg.sv
// Shared decode constants, control bundle and sequencer state type
// for the pipelined control unit.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_PASSB  = 5'd10;
    localparam logic [4:0] ALU_MUL    = 5'd16;
    localparam logic [4:0] ALU_MULH   = 5'd17;
    localparam logic [4:0] ALU_MULHSU = 5'd18;
    localparam logic [4:0] ALU_MULHU  = 5'd19;
    localparam logic [4:0] ALU_DIV    = 5'd20;
    localparam logic [4:0] ALU_DIVU   = 5'd21;
    localparam logic [4:0] ALU_REM    = 5'd22;
    localparam logic [4:0] ALU_REMU   = 5'd23;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic {ST_IDLE, ST_BUSY} md_state_e;

    typedef struct packed {
        logic       reg_write;
        logic [2:0] imm_sel;
        logic       operand_a;
        logic       operand_b;
        logic [1:0] mem_to_reg;
        logic       load;
        logic       store;
        logic       branch;
        logic       jalr;
        logic       mem_en;
        logic       next_sel;
    } ctrl_t;

    function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: IDLE/BUSY FSM, latency down-counter
// and the pipeline stall it raises.
module md_sequencer
    import rv_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 1,
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_is_div,
    input  logic i_flush,
    output logic o_busy,
    output logic o_last,
    output logic o_stall
);

    md_state_e  r_state;
    md_state_e  w_state_nxt;
    logic [5:0] r_cnt;
    logic [5:0] w_cnt_nxt;
    logic [5:0] w_load;

    assign w_load = i_is_div ? 6'(DIV_CYCLES - 1) : 6'(MUL_CYCLES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_BUSY;
                    w_cnt_nxt   = w_load;
                end
            end
            ST_BUSY: begin
                if (i_flush || r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 6'd1;
                end
            end
        endcase
    end

    // The entry cycle stalls too, so an op of latency L stalls exactly L cycles.
    always_comb begin
        o_busy  = (r_state == ST_BUSY);
        o_last  = o_busy && (r_cnt == '0) && !i_flush;
        o_stall = !rst && ((!o_busy && i_start) ||
                           (o_busy && (r_cnt != '0) && !i_flush));
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// Registered RV32IM instruction decode with a multi-cycle
// multiply/divide sequencer.
module pipelined_control_unit
    import rv_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 1,
    parameter int DIV_CYCLES = 32,
    parameter int ALU_CTRL_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            opcode,
    input  logic [2:0]            fun3,
    input  logic [6:0]            fun7,
    input  logic                  valid,
    input  logic                  load_control,
    input  logic                  flush,
    output logic                  reg_write,
    output logic [2:0]            imm_sel,
    output logic                  operand_a,
    output logic                  operand_b,
    output logic [1:0]            mem_to_reg,
    output logic                  load,
    output logic                  store,
    output logic                  branch,
    output logic                  jalr_out,
    output logic                  mem_en,
    output logic                  next_sel,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal,
    output logic                  md_done,
    output logic                  stall
);

    ctrl_t                 w_dec;
    logic [4:0]            w_alu;
    logic                  w_legal;
    logic                  w_mop;
    logic                  w_multi;
    logic                  w_start;
    logic                  w_busy;
    logic                  w_last;
    ctrl_t                 r_ctl;
    ctrl_t                 w_ctl_nxt;
    logic [ALU_CTRL_W-1:0] r_alu;
    logic [ALU_CTRL_W-1:0] w_alu_nxt;
    logic                  r_illegal;
    logic                  w_illegal_nxt;
    logic                  r_md_done;
    logic                  w_md_done_nxt;

    assign w_multi = fun3[2] ? (DIV_CYCLES > 1) : (MUL_CYCLES > 1);
    assign w_start = valid && !flush && !load_control && w_mop && w_multi;

    always_comb begin
        w_dec   = '0;
        w_alu   = ALU_ADD;
        w_legal = 1'b1;
        w_mop   = 1'b0;
        case (opcode)
            OP_R: begin
                w_dec.reg_write = 1'b1;
                if (fun7 == F7_MEXT) begin
                    w_mop           = 1'b1;
                    w_alu           = ALU_MUL | {2'b00, fun3};
                    w_dec.reg_write = !w_multi;
                end else if (fun7 == F7_BASE) begin
                    w_alu = alu_base(fun3, 1'b0);
                end else if (fun7 == F7_ALT && (fun3 == 3'b000 || fun3 == 3'b101)) begin
                    w_alu = alu_base(fun3, 1'b1);
                end else begin
                    w_legal = 1'b0;
                end
            end
            OP_I: begin
                w_dec.reg_write = 1'b1;
                w_dec.imm_sel   = IMM_I;
                w_dec.operand_b = 1'b1;
                // Only shifts carry a funct7; elsewhere those bits are immediate.
                w_alu = alu_base(fun3, fun3 == 3'b101 && fun7[5]);
                if (fun3 == 3'b001 && fun7 != F7_BASE)
                    w_legal = 1'b0;
                if (fun3 == 3'b101 && fun7 != F7_BASE && fun7 != F7_ALT)
                    w_legal = 1'b0;
            end
            OP_LOAD: begin
                w_dec.reg_write  = 1'b1;
                w_dec.imm_sel    = IMM_I;
                w_dec.operand_b  = 1'b1;
                w_dec.mem_to_reg = WB_MEM;
                w_dec.load       = 1'b1;
                w_dec.mem_en     = 1'b1;
            end
            OP_STORE: begin
                w_dec.imm_sel   = IMM_S;
                w_dec.operand_b = 1'b1;
                w_dec.store     = 1'b1;
                w_dec.mem_en    = 1'b1;
            end
            OP_BRANCH: begin
                w_dec.imm_sel   = IMM_B;
                w_dec.operand_a = 1'b1;
                w_dec.operand_b = 1'b1;
                w_dec.branch    = 1'b1;
            end
            OP_JAL: begin
                w_dec.reg_write  = 1'b1;
                w_dec.imm_sel    = IMM_J;
                w_dec.operand_a  = 1'b1;
                w_dec.operand_b  = 1'b1;
                w_dec.mem_to_reg = WB_PC4;
                w_dec.next_sel   = 1'b1;
            end
            OP_JALR: begin
                w_dec.reg_write  = 1'b1;
                w_dec.imm_sel    = IMM_I;
                w_dec.operand_b  = 1'b1;
                w_dec.mem_to_reg = WB_PC4;
                w_dec.jalr       = 1'b1;
                w_dec.next_sel   = 1'b1;
            end
            OP_LUI: begin
                w_dec.reg_write = 1'b1;
                w_dec.imm_sel   = IMM_U;
                w_dec.operand_b = 1'b1;
                w_alu           = ALU_PASSB;
            end
            OP_AUIPC: begin
                w_dec.reg_write = 1'b1;
                w_dec.imm_sel   = IMM_U;
                w_dec.operand_a = 1'b1;
                w_dec.operand_b = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    md_sequencer #(
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES)
    ) u_md_sequencer (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_is_div(fun3[2]),
        .i_flush (flush),
        .o_busy  (w_busy),
        .o_last  (w_last),
        .o_stall (stall)
    );

    // Priority: flush, then an in-flight M-op, then bubble requests, then decode.
    always_comb begin
        w_ctl_nxt     = '0;
        w_alu_nxt     = '0;
        w_illegal_nxt = 1'b0;
        w_md_done_nxt = 1'b0;
        if (!flush) begin
            if (w_busy) begin
                w_ctl_nxt           = r_ctl;
                w_ctl_nxt.reg_write = w_last;
                w_alu_nxt           = r_alu;
                w_md_done_nxt       = w_last;
            end else if (valid && !load_control) begin
                if (!w_legal) begin
                    w_illegal_nxt = 1'b1;
                end else begin
                    w_ctl_nxt = w_dec;
                    w_alu_nxt = ALU_CTRL_W'(w_alu);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctl     <= '0;
            r_alu     <= '0;
            r_illegal <= 1'b0;
            r_md_done <= 1'b0;
        end else begin
            r_ctl     <= w_ctl_nxt;
            r_alu     <= w_alu_nxt;
            r_illegal <= w_illegal_nxt;
            r_md_done <= w_md_done_nxt;
        end
    end

    assign reg_write   = r_ctl.reg_write;
    assign imm_sel     = r_ctl.imm_sel;
    assign operand_a   = r_ctl.operand_a;
    assign operand_b   = r_ctl.operand_b;
    assign mem_to_reg  = r_ctl.mem_to_reg;
    assign load        = r_ctl.load;
    assign store       = r_ctl.store;
    assign branch      = r_ctl.branch;
    assign jalr_out    = r_ctl.jalr;
    assign mem_en      = r_ctl.mem_en;
    assign next_sel    = r_ctl.next_sel;
    assign alu_control = r_alu;
    assign illegal     = r_illegal;
    assign md_done     = r_md_done;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench: instance A (MUL=1, DIV=32) and instance B (MUL=3, DIV=4)
// share inputs; each check targets the instance whose latencies it needs.
module tb_pipelined_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] fun3;
    logic [6:0] fun7;
    logic       valid;
    logic       load_control;
    logic       flush;

    wire [20:0] out_a;
    wire [20:0] out_b;
    wire        stall_a;
    wire        stall_b;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pipelined_control_unit #(
        .MUL_CYCLES(1), .DIV_CYCLES(32), .ALU_CTRL_W(5)
    ) u_dut_a (
        .clk(clk), .rst(rst), .opcode(opcode), .fun3(fun3), .fun7(fun7),
        .valid(valid), .load_control(load_control), .flush(flush),
        .reg_write(out_a[20]), .imm_sel(out_a[19:17]),
        .operand_a(out_a[16]), .operand_b(out_a[15]),
        .mem_to_reg(out_a[14:13]), .load(out_a[12]), .store(out_a[11]),
        .branch(out_a[10]), .jalr_out(out_a[9]), .mem_en(out_a[8]),
        .next_sel(out_a[7]), .alu_control(out_a[6:2]),
        .illegal(out_a[1]), .md_done(out_a[0]), .stall(stall_a)
    );

    pipelined_control_unit #(
        .MUL_CYCLES(3), .DIV_CYCLES(4), .ALU_CTRL_W(5)
    ) u_dut_b (
        .clk(clk), .rst(rst), .opcode(opcode), .fun3(fun3), .fun7(fun7),
        .valid(valid), .load_control(load_control), .flush(flush),
        .reg_write(out_b[20]), .imm_sel(out_b[19:17]),
        .operand_a(out_b[16]), .operand_b(out_b[15]),
        .mem_to_reg(out_b[14:13]), .load(out_b[12]), .store(out_b[11]),
        .branch(out_b[10]), .jalr_out(out_b[9]), .mem_en(out_b[8]),
        .next_sel(out_b[7]), .alu_control(out_b[6:2]),
        .illegal(out_b[1]), .md_done(out_b[0]), .stall(stall_b)
    );

    function automatic logic [20:0] pk(
        input int rw, input int imm, input int oa, input int ob,
        input int m2r, input int ld, input int st, input int br,
        input int jr, input int me, input int ns, input int alu,
        input int ill, input int md);
        return {rw[0], imm[2:0], oa[0], ob[0], m2r[1:0], ld[0], st[0],
                br[0], jr[0], me[0], ns[0], alu[4:0], ill[0], md[0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic v,
                         input logic lc, input logic fl);
        opcode       = op;
        fun3         = f3;
        fun7         = f7;
        valid        = v;
        load_control = lc;
        flush        = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(7'd0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
    endtask

    task automatic dec_chk(input string tag, input logic v, input logic lc,
                           input logic fl, input logic [6:0] op,
                           input logic [2:0] f3, input logic [6:0] f7,
                           input logic [20:0] exp);
        drive(op, f3, f7, v, lc, fl);
        #1;
        chk({tag, "_stall"}, 32'(stall_a), 32'd0);
        tick();
        chk(tag, 32'(out_a), 32'(exp));
    endtask

    task automatic md_run_b(input string tag, input int len, input int alu);
        int n;
        n = 0;
        #1;
        while (stall_b && n < 40) begin
            n++;
            tick();
        end
        chk({tag, "_stall_len"}, 32'(n), 32'(len));
        chk({tag, "_hold"}, 32'(out_b), 32'(pk(0,0,0,0,0,0,0,0,0,0,0,alu,0,0)));
        tick();
        chk({tag, "_done"}, 32'(out_b), 32'(pk(1,0,0,0,0,0,0,0,0,0,0,alu,0,1)));
    endtask

    task automatic quiet_a(input string tag);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_a != '0 || stall_a) bad = 1'b1;
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(7'b0110011, 3'b100, 7'b0000001, 1'b1, 1'b0, 1'b0);
        #12;
        chk("rst_out_a", 32'(out_a), 32'd0);
        chk("rst_stall_a", 32'(stall_a), 32'd0);
        chk("rst_stall_b", 32'(stall_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        dec_chk("add", 1, 0, 0, 7'b0110011, 3'b000, 7'b0000000,
                pk(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        dec_chk("sub", 1, 0, 0, 7'b0110011, 3'b000, 7'b0100000,
                pk(1,0,0,0,0,0,0,0,0,0,0,1,0,0));
        dec_chk("sra", 1, 0, 0, 7'b0110011, 3'b101, 7'b0100000,
                pk(1,0,0,0,0,0,0,0,0,0,0,7,0,0));
        dec_chk("and", 1, 0, 0, 7'b0110011, 3'b111, 7'b0000000,
                pk(1,0,0,0,0,0,0,0,0,0,0,9,0,0));
        dec_chk("addi", 1, 0, 0, 7'b0010011, 3'b000, 7'b0100000,
                pk(1,1,0,1,0,0,0,0,0,0,0,0,0,0));
        dec_chk("srai", 1, 0, 0, 7'b0010011, 3'b101, 7'b0100000,
                pk(1,1,0,1,0,0,0,0,0,0,0,7,0,0));
        dec_chk("slli_bad", 1, 0, 0, 7'b0010011, 3'b001, 7'b0100000,
                pk(0,0,0,0,0,0,0,0,0,0,0,0,1,0));
        dec_chk("lw", 1, 0, 0, 7'b0000011, 3'b010, 7'b0000000,
                pk(1,1,0,1,1,1,0,0,0,1,0,0,0,0));
        dec_chk("sw", 1, 0, 0, 7'b0100011, 3'b010, 7'b0000000,
                pk(0,2,0,1,0,0,1,0,0,1,0,0,0,0));
        dec_chk("beq", 1, 0, 0, 7'b1100011, 3'b000, 7'b0000000,
                pk(0,3,1,1,0,0,0,1,0,0,0,0,0,0));
        dec_chk("jal", 1, 0, 0, 7'b1101111, 3'b000, 7'b0000000,
                pk(1,5,1,1,2,0,0,0,0,0,1,0,0,0));
        dec_chk("jalr", 1, 0, 0, 7'b1100111, 3'b000, 7'b0000000,
                pk(1,1,0,1,2,0,0,0,1,0,1,0,0,0));
        dec_chk("lui", 1, 0, 0, 7'b0110111, 3'b000, 7'b0000000,
                pk(1,4,0,1,0,0,0,0,0,0,0,10,0,0));
        dec_chk("auipc", 1, 0, 0, 7'b0010111, 3'b000, 7'b0000000,
                pk(1,4,1,1,0,0,0,0,0,0,0,0,0,0));
        dec_chk("mul_l1", 1, 0, 0, 7'b0110011, 3'b000, 7'b0000001,
                pk(1,0,0,0,0,0,0,0,0,0,0,16,0,0));
        dec_chk("mul_l1_after", 0, 0, 0, 7'b0110011, 3'b000, 7'b0000001,
                pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        dec_chk("mulhu_l1", 1, 0, 0, 7'b0110011, 3'b011, 7'b0000001,
                pk(1,0,0,0,0,0,0,0,0,0,0,19,0,0));
        dec_chk("ill_op", 1, 0, 0, 7'b1111111, 3'b000, 7'b0000000,
                pk(0,0,0,0,0,0,0,0,0,0,0,0,1,0));
        dec_chk("ill_clear", 0, 0, 0, 7'b1111111, 3'b000, 7'b0000000,
                pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        dec_chk("ill_f7", 1, 0, 0, 7'b0110011, 3'b000, 7'b0000010,
                pk(0,0,0,0,0,0,0,0,0,0,0,0,1,0));
        dec_chk("ill_lc", 1, 1, 0, 7'b1111111, 3'b000, 7'b0000000,
                pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        dec_chk("ill_flush", 1, 0, 1, 7'b1111111, 3'b000, 7'b0000000,
                pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        dec_chk("add_lc", 1, 1, 0, 7'b0110011, 3'b000, 7'b0000000,
                pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        dec_chk("add_flush", 1, 0, 1, 7'b0110011, 3'b000, 7'b0000000,
                pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        dec_chk("div_lc", 1, 1, 0, 7'b0110011, 3'b100, 7'b0000001,
                pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0));

        do_reset();
        drive(7'b0110011, 3'b100, 7'b0000001, 1'b1, 1'b0, 1'b0);
        md_run_b("div4", 4, 20);
        md_run_b("div4_b2b", 4, 20);
        drive(7'b0110011, 3'b000, 7'b0000001, 1'b1, 1'b0, 1'b0);
        md_run_b("mul3", 3, 16);
        drive(7'b0110011, 3'b110, 7'b0000001, 1'b1, 1'b0, 1'b0);
        md_run_b("rem4", 4, 22);
        drive(7'd0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("b_done_one_cycle", 32'(out_b), 32'd0);

        do_reset();
        drive(7'b0110011, 3'b100, 7'b0000001, 1'b1, 1'b0, 1'b0);
        #1;
        chk("a_div_enter_stall", 32'(stall_a), 32'd1);
        for (int i = 0; i < 5; i++) tick();
        chk("a_busy5_stall", 32'(stall_a), 32'd1);
        chk("a_busy5_hold", 32'(out_a), 32'(pk(0,0,0,0,0,0,0,0,0,0,0,20,0,0)));
        drive(7'b0110011, 3'b100, 7'b0000001, 1'b1, 1'b0, 1'b1);
        #1;
        chk("a_flush_stall_drop", 32'(stall_a), 32'd0);
        tick();
        chk("a_flush_bubble", 32'(out_a), 32'd0);
        drive(7'd0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        quiet_a("a_flush_no_done");
        dec_chk("add_after_flush", 1, 0, 0, 7'b0110011, 3'b000, 7'b0000000,
                pk(1,0,0,0,0,0,0,0,0,0,0,0,0,0));

        drive(7'b0110011, 3'b101, 7'b0000001, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        chk("a_busy2_hold", 32'(out_a), 32'(pk(0,0,0,0,0,0,0,0,0,0,0,21,0,0)));
        #2;
        rst = 1'b1;
        #1;
        chk("a_rst_async_out", 32'(out_a), 32'd0);
        chk("a_rst_async_stall", 32'(stall_a), 32'd0);
        drive(7'd0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        quiet_a("a_rst_no_done");
        dec_chk("add_after_rst", 1, 0, 0, 7'b0110011, 3'b000, 7'b0000000,
                pk(1,0,0,0,0,0,0,0,0,0,0,0,0,0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipelined_control_unit.md
PIPELINED_CONTROL_UNIT -- requirements
Module: pipelined_control_unit

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 1: M-extension multiply latency in cycles, legal range 1..64.
REQ-002 SHALL have parameter DIV_CYCLES, default 32: divide/remainder latency in cycles, legal range 1..64.
REQ-003 SHALL have parameter ALU_CTRL_W, default 5: width of alu_control.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have inputs opcode (7), fun3 (3), fun7 (7) and valid (1): the instruction fields being decoded and their qualifier.
REQ-007 SHALL have input load_control (1), the load-use hazard bubble request, and input flush (1), the branch/jump squash.
REQ-008 SHALL have the following registered outputs, all 1 bit unless noted: reg_write, imm_sel (3), operand_a, operand_b, mem_to_reg (2), load, store, branch, jalr_out, mem_en, next_sel, alu_control (ALU_CTRL_W).
REQ-009 SHALL have registered outputs illegal (1) and md_done (1), plus combinational output stall (1).

Function
REQ-010 SHALL decode R, I, load, store, branch, JAL, JALR, LUI, AUIPC and M-extension ops (R-type with fun7=0000001) and register the resulting controls, giving 1 cycle from inputs to outputs.
REQ-011 SHALL register a bubble (all outputs 0) when valid=0, load_control=1 or flush=1.
REQ-012 SHALL register a bubble with illegal=1 for one cycle when valid=1 and the opcode or fun7 is not in the decode table.
REQ-013 SHALL treat an M-op as multi-cycle when its latency L (MUL_CYCLES for fun3[2]=0, DIV_CYCLES for fun3[2]=1) is greater than 1; when L=1 it SHALL be decoded as a normal single-cycle ALU op with reg_write=1.
REQ-014 SHALL implement the sequencer FSM with states IDLE and BUSY and a 6-bit down-counter.
REQ-015 IDLE -> BUSY SHALL occur when a multi-cycle M-op is decoded with valid=1, flush=0 and load_control=0; on that edge the counter loads L-1 and the controls register with correct alu_control and reg_write=0.
REQ-016 In BUSY, SHALL decrement the counter each cycle, hold the registered controls, and ignore the decode inputs.
REQ-017 BUSY -> IDLE SHALL occur on the edge where counter==0; on that edge reg_write=1 and md_done=1 SHALL register for exactly one cycle.
REQ-018 stall SHALL equal (IDLE and a multi-cycle M-op is entering, per REQ-015) OR (BUSY and counter!=0), giving exactly L consecutive stall cycles per op.
REQ-019 SHALL make flush in BUSY abort to IDLE, clear the counter, and register a bubble (no md_done); stall SHALL drop in the same cycle.
REQ-020 SHALL give priority flush > load_control > illegal > decode when these coincide.
REQ-021 SHALL leave the upstream registers holding the instruction while stall=1; a back-to-back M-op in the cycle after exit SHALL start a new sequence normally.

Reset
REQ-022 SHALL, while rst=1, force the FSM to IDLE, the counter to 0, all registered outputs to 0, and stall to 0, independent of clk.
REQ-023 SHALL, on rst assertion mid-BUSY, abandon the sequence with no md_done or reg_write pulse.

Structure
REQ-024 SHALL place the opcode constants, ALU_* alu_control encodings, imm_sel encodings and the FSM state typedef in the shared package rv_ctrl_pkg.
REQ-025 SHALL place the FSM, counter and stall logic in one sub-module, md_sequencer; the decode table SHALL stay in the top level.

Verification
REQ-026 ADD (opcode 0110011, fun3 000, fun7 0000000, valid 1) -> next cycle reg_write=1, alu_control=ALU_ADD, stall=0.
REQ-027 DIV with DIV_CYCLES=4 -> stall high for exactly 4 cycles, then md_done=1 and reg_write=1 for 1 cycle, alu_control=ALU_DIV.
REQ-028 MUL with MUL_CYCLES=1 -> no stall, reg_write=1 next cycle, md_done stays 0.
REQ-029 DIV with DIV_CYCLES=32 and flush at BUSY cycle 5 -> stall drops that cycle, next outputs are all 0, and no md_done.
REQ-030 opcode 1111111 with valid=1 -> illegal=1 for 1 cycle, all other outputs 0; the same opcode with load_control=1 -> illegal=0.
REQ-031 rst pulse at BUSY cycle 2 -> all outputs 0 immediately, FSM in IDLE, and the next ADD decodes normally.
